// File: rtl/seq_alu_if.sv
// Request/response bus between a requester and seq_alu: start handshake, operands, result and flags.
interface seq_alu_if #(
   parameter int unsigned DATASIZE = 16
);
   logic                start_i;
   logic [2:0]          op_i;
   logic [DATASIZE-1:0] a_i;
   logic [DATASIZE-1:0] b_i;
   logic                busy_o;
   logic                done_o;
   logic [DATASIZE-1:0] result_o;
   logic                carry_o;
   logic                zero_o;

   modport master (
      output start_i, op_i, a_i, b_i,
      input  busy_o, done_o, result_o, carry_o, zero_o
   );

   modport slave (
      input  start_i, op_i, a_i, b_i,
      output busy_o, done_o, result_o, carry_o, zero_o
   );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/sub ops and a DATASIZE-cycle shift-add multiplier,
// with registered result, carry and zero flags and a one-cycle done pulse.
module seq_alu #(
   parameter int unsigned DATASIZE = 16
) (
   input  logic     clock_i,
   input  logic     reset_i,
   seq_alu_if.slave bus
);
   localparam int unsigned DW = DATASIZE;
   localparam int unsigned PW = 2 * DATASIZE;
   localparam int unsigned CW = $clog2(DATASIZE) + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(DATASIZE - 1);

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_NOT  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        r_state, w_state_nxt;
   logic          r_busy, r_done;
   logic          r_carry, w_carry_nxt;
   logic          r_zero, w_zero_nxt;
   logic [DW-1:0] r_result, w_result_nxt;
   logic [DW-1:0] r_mplier, w_mplier_nxt;
   logic [PW-1:0] r_mcand, w_mcand_nxt;
   logic [PW-1:0] r_prod, w_prod_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [DW:0]   w_sum;
   logic [DW:0]   w_diff;
   logic [PW-1:0] w_prod_step;

   // Extra top bit of the sum is the carry out; of the difference, the unsigned borrow.
   assign w_sum       = {1'b0, bus.a_i} + {1'b0, bus.b_i};
   assign w_diff      = {1'b0, bus.a_i} - {1'b0, bus.b_i};
   assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : '0);
   assign w_zero_nxt  = (w_result_nxt == '0);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_result_nxt = r_result;
      w_carry_nxt  = r_carry;
      w_mplier_nxt = r_mplier;
      w_mcand_nxt  = r_mcand;
      w_prod_nxt   = r_prod;
      w_cnt_nxt    = r_cnt;
      case (r_state)
         IDLE: begin
            if (bus.start_i) begin
               w_mplier_nxt = bus.b_i;
               w_mcand_nxt  = PW'(bus.a_i);
               w_prod_nxt   = '0;
               w_cnt_nxt    = '0;
               if (bus.op_i == OP_MUL) begin
                  w_state_nxt = MUL;
               end else begin
                  w_state_nxt = DONE;
                  w_carry_nxt = 1'b0;
                  case (bus.op_i)
                     OP_PASS: w_result_nxt = bus.b_i;
                     OP_ADD: begin
                        w_result_nxt = w_sum[DW-1:0];
                        w_carry_nxt  = w_sum[DW];
                     end
                     OP_SUB: begin
                        w_result_nxt = w_diff[DW-1:0];
                        w_carry_nxt  = w_diff[DW];
                     end
                     OP_AND:  w_result_nxt = bus.a_i & bus.b_i;
                     OP_OR:   w_result_nxt = bus.a_i | bus.b_i;
                     OP_XOR:  w_result_nxt = bus.a_i ^ bus.b_i;
                     OP_NOT:  w_result_nxt = ~bus.a_i;
                     default: w_result_nxt = bus.b_i;
                  endcase
               end
            end
         end
         MUL: begin
            // One multiplier bit per edge, LSB first; the final step loads result and overflow.
            w_prod_nxt   = w_prod_step;
            w_mcand_nxt  = r_mcand << 1;
            w_mplier_nxt = r_mplier >> 1;
            w_cnt_nxt    = r_cnt + CW'(1);
            if (r_cnt == LAST_STEP) begin
               w_state_nxt  = DONE;
               w_result_nxt = w_prod_step[DW-1:0];
               w_carry_nxt  = |w_prod_step[PW-1:DW];
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b1;
         r_mplier <= '0;
         r_mcand  <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else begin
         r_busy   <= (w_state_nxt != IDLE);
         r_done   <= (w_state_nxt == DONE);
         r_result <= w_result_nxt;
         r_carry  <= w_carry_nxt;
         r_zero   <= w_zero_nxt;
         r_mplier <= w_mplier_nxt;
         r_mcand  <= w_mcand_nxt;
         r_prod   <= w_prod_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   assign bus.busy_o   = r_busy;
   assign bus.done_o   = r_done;
   assign bus.result_o = r_result;
   assign bus.carry_o  = r_carry;
   assign bus.zero_o   = r_zero;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed corner cases plus random traffic, checked every cycle
// against a latency/result model built from plain arithmetic.
module tb_seq_alu;
   localparam int unsigned DW = 16;
   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   seq_alu_if #(.DATASIZE(DW)) bus ();
   seq_alu #(.DATASIZE(DW)) dut (.clock_i(clk), .reset_i(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result: {carry, result} from the opcode rules with 64-bit arithmetic.
   function automatic logic [DW:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      longint unsigned ua, ub, mask, r;
      logic c;
      ua = 64'(a); ub = 64'(b); mask = (64'd1 << DW) - 64'd1; c = 1'b0;
      case (op)
         OP_PASS: r = ub;
         OP_ADD:  begin r = ua + ub; c = (r > mask); end
         OP_SUB:  begin r = ua - ub; c = (ua < ub); end
         OP_AND:  r = ua & ub;
         OP_OR:   r = ua | ub;
         OP_XOR:  r = ua ^ ub;
         OP_MUL:  begin r = ua * ub; c = (r > mask); end
         default: r = ~ua;
      endcase
      return {c, DW'(r & mask)};
   endfunction

   // Model: m_wait counts edges (start edge included) until the result appears.
   logic          m_busy = 1'b0, m_done = 1'b0, m_carry = 1'b0, m_zero = 1'b1;
   logic [DW-1:0] m_res = '0;
   logic [DW:0]   m_pend = '0;
   int            m_wait = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_carry = 1'b0; m_zero = 1'b1; m_wait = 0;
      end else if (m_done) begin
         m_done = 1'b0; m_busy = 1'b0;
      end else begin
         if (!m_busy && bus.start_i) begin
            m_busy = 1'b1;
            m_pend = alu_ref(bus.op_i, bus.a_i, bus.b_i);
            m_wait = (bus.op_i == OP_MUL) ? DW + 1 : 1;
         end
         if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin
               m_res = m_pend[DW-1:0]; m_carry = m_pend[DW]; m_zero = (m_res == '0); m_done = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", 32'(bus.busy_o), 32'(m_busy));
      chk("done", 32'(bus.done_o), 32'(m_done));
      chk("result", 32'(bus.result_o), 32'(m_res));
      chk("carry", 32'(bus.carry_o), 32'(m_carry));
      chk("zero", 32'(bus.zero_o), 32'(m_zero));
   end

   function automatic logic [DW-1:0] pick();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         2:       return DW'($urandom_range(0, 15));
         default: return DW'($urandom);
      endcase
   endfunction

   // Issue one op from idle, scramble inputs after capture, wait (bounded) for done.
   task automatic run_op(input string name, input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] er, input logic ec,
                         input logic ez, input int edges);
      int  n, nbusy;
      bit  seen;
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b;
      @(negedge clk);
      bus.start_i = 1'b0; bus.op_i = 3'($urandom); bus.a_i = pick(); bus.b_i = pick();
      n = 0; nbusy = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus.done_o) seen = 1'b1;
         else begin
            if (bus.busy_o) nbusy++;
            @(negedge clk);
            n++;
         end
      end
      chk({name, "_seen"}, 32'(seen), 32'd1);
      chk({name, "_edges"}, 32'(n), 32'(edges));
      chk({name, "_busycyc"}, 32'(nbusy), 32'(edges));
      chk({name, "_res"}, 32'(bus.result_o), 32'(er));
      chk({name, "_carry"}, 32'(bus.carry_o), 32'(ec));
      chk({name, "_zero"}, 32'(bus.zero_o), 32'(ez));
      chk({name, "_model"}, 32'({m_carry, m_res}), 32'({ec, er}));
   endtask

   initial begin
      int          ndone;
      logic [DW-1:0] dres;
      bus.start_i = 1'b0; bus.op_i = '0; bus.a_i = '0; bus.b_i = '0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_done", 32'(bus.done_o), 32'd0);
      chk("rst_result", 32'(bus.result_o), 32'd0);
      chk("rst_zero", 32'(bus.zero_o), 32'd1);
      rst = 1'b0;

      run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 0);
      run_op("sub_borrow", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 0);
      run_op("sub_equal", OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 0);
      run_op("mul_small", OP_MUL, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 16);
      run_op("mul_ovf", OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 16);
      run_op("not_a", 3'b111, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 0);

      // start held high with XOR while a MUL runs: one MUL done, then XOR from idle
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = OP_MUL; bus.a_i = 16'h0012; bus.b_i = 16'h0034;
      @(negedge clk);
      bus.op_i = OP_XOR; bus.a_i = 16'hA5A5; bus.b_i = 16'h0F0F;
      ndone = 0; dres = '0;
      for (int i = 0; i < 18; i++) begin
         if (bus.done_o) begin ndone++; dres = bus.result_o; end
         @(negedge clk);
      end
      chk("hold_ndone", 32'(ndone), 32'd1);
      chk("hold_mulres", 32'(dres), 32'h03A8);
      chk("hold_xor_done", 32'(bus.done_o), 32'd1);
      chk("hold_xor_res", 32'(bus.result_o), 32'hAAAA);
      bus.start_i = 1'b0;
      repeat (2) @(negedge clk);

      // reset in the middle of a MUL, then PASS right after release
      bus.start_i = 1'b1; bus.op_i = OP_MUL; bus.a_i = 16'h0123; bus.b_i = 16'h0456;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(bus.busy_o), 32'd0);
      chk("midrst_done", 32'(bus.done_o), 32'd0);
      chk("midrst_result", 32'(bus.result_o), 32'd0);
      chk("midrst_carry", 32'(bus.carry_o), 32'd0);
      chk("midrst_zero", 32'(bus.zero_o), 32'd1);
      @(negedge clk);
      chk("midrst_nodone", 32'(bus.done_o), 32'd0);
      rst = 1'b0;
      bus.start_i = 1'b1; bus.op_i = OP_PASS; bus.a_i = 16'hDEAD; bus.b_i = 16'h1234;
      @(negedge clk);
      bus.start_i = 1'b0;
      chk("pass_done", 32'(bus.done_o), 32'd1);
      chk("pass_res", 32'(bus.result_o), 32'h1234);

      // random traffic: starts at any time, inputs churn every cycle, rare resets
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         bus.start_i = ($urandom_range(0, 3) == 0);
         bus.op_i    = 3'($urandom);
         bus.a_i     = pick();
         bus.b_i     = pick();
         rst         = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      rst = 1'b0; bus.start_i = 1'b0;
      repeat (20) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
